apb_mem_slave: RTL and testbench



---
 rtl/apb_mem_slave.sv | 106 ++++++++++
 tb/tb_apb_mem_slave.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// APB completer memory with fixed wait states, a read-only upper region
// and an error response for addresses beyond the storage depth.
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int RO_BASE     = 48,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr
);

  // A zero-wait build still needs a one-bit counter so the vector is legal.
  localparam int WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [WCNT_W-1:0]   WCNT_LOAD = WCNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] RO_LIM    = (ADDR_WIDTH + 1)'(RO_BASE);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [WCNT_W-1:0]     r_wcnt;
  logic [ADDR_WIDTH-1:0] r_addrL;
  logic                  r_writeL;
  logic [DATA_WIDTH-1:0] r_wdataL;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_setup;
  logic                  w_pready;
  logic                  w_err;
  logic                  w_complete;
  logic                  w_commit;
  logic [IDX_W-1:0]      w_idx;

  // Everything here is decoded from registers except the phase qualifiers.
  assign w_setup    = (r_state == IDLE) && pselx && !penable;
  assign w_pready   = (r_state == ACCESS) && (r_wcnt == '0);
  assign w_err      = ({1'b0, r_addrL} >= DEPTH_LIM) ||
                      (r_writeL && ({1'b0, r_addrL} >= RO_LIM));
  assign w_complete = w_pready && pselx && penable;
  assign w_commit   = w_complete && r_writeL && !w_err;
  assign w_idx      = r_addrL[IDX_W-1:0];

  // State register.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next state: setup enters ACCESS; completion or a dropped select leaves it.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_setup) w_nextState = ACCESS;
      ACCESS:  if (!pselx || w_complete) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Capture the transfer at the setup edge and count down the wait states.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_wcnt   <= '0;
      r_addrL  <= '0;
      r_writeL <= 1'b0;
      r_wdataL <= '0;
    end else if (w_setup) begin
      r_wcnt   <= WCNT_LOAD;
      r_addrL  <= paddr;
      r_writeL <= pwrite;
      r_wdataL <= pwdata;
    end else if ((r_state == ACCESS) && pselx && penable && (r_wcnt != '0)) begin
      r_wcnt   <= r_wcnt - 1'b1;
    end
  end

  // Storage: cleared on reset, written only by a completing legal write.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_commit) begin
      r_mem[w_idx] <= r_wdataL;
    end
  end

  // Outputs: response only in the ready cycle, read data masked otherwise.
  always_comb begin
    pready  = w_pready;
    pslverr = w_pready && w_err;
    prdata  = '0;
    if (w_pready && !r_writeL && !w_err) prdata = r_mem[w_idx];
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench for apb_mem_slave: a vector table on the default
// two-wait build plus hand sequences for abort, reset and zero-wait cases.
module tb_apb_mem_slave;

  logic        pclk;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  logic        psel0, penable0, pwrite0;
  logic [7:0]  paddr0;
  logic [31:0] pwdata0;
  logic        pready0;
  logic [31:0] prdata0;
  logic        pslverr0;

  int nChecks = 0;
  int nFail   = 0;

  apb_mem_slave dut (
    .pclk(pclk), .preset(preset), .pselx(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  apb_mem_slave #(.WAIT_CYCLES(0)) dut0 (
    .pclk(pclk), .preset(preset), .pselx(psel0), .penable(penable0),
    .pwrite(pwrite0), .paddr(paddr0), .pwdata(pwdata0),
    .pready(pready0), .prdata(prdata0), .pslverr(pslverr0)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Full transfer on the two-wait DUT; returns on the edge after completion
  // with select still high so a following call forms a back-to-back setup.
  task automatic applyStimulus(input logic write, input logic [7:0] addr,
                               input logic [31:0] wdata, input string name,
                               output logic [31:0] rdata, output logic err,
                               output int waits, output logic done);
    psel = 1'b1; penable = 1'b0; pwrite = write; paddr = addr; pwdata = wdata;
    @(negedge pclk);
    checkOutput({name, " setup pready"}, 32'(pready), 32'd0);
    @(posedge pclk); #1;
    penable = 1'b1;
    paddr   = addr ^ 8'hC0;
    pwdata  = ~wdata;
    pwrite  = ~write;
    waits = 0; done = 1'b0; rdata = '0; err = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge pclk);
      if (pready) begin
        done  = 1'b1;
        rdata = prdata;
        err   = pslverr;
      end else begin
        waits++;
      end
      @(posedge pclk); #1;
    end
  endtask

  task automatic goIdle();
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  // Runs one transfer and checks latency, data and error against expectations.
  task automatic runChecked(input logic write, input logic [7:0] addr,
                            input logic [31:0] wdata, input logic [31:0] expData,
                            input logic expErr, input string name);
    logic [31:0] rd;
    logic        er;
    int          w;
    logic        dn;
    applyStimulus(write, addr, wdata, name, rd, er, w, dn);
    checkOutput({name, " completed"}, 32'(dn), 32'd1);
    checkOutput({name, " waits"}, 32'(w), 32'd2);
    checkOutput({name, " prdata"}, rd, expData);
    checkOutput({name, " pslverr"}, 32'(er), 32'(expErr));
  endtask

  // One zero-wait transfer on dut0: setup cycle then a single access cycle.
  task automatic applyStimulus0(input logic write, input logic [7:0] addr,
                                input logic [31:0] wdata, input logic [31:0] expData,
                                input logic expErr, input string name);
    psel0 = 1'b1; penable0 = 1'b0; pwrite0 = write; paddr0 = addr; pwdata0 = wdata;
    @(negedge pclk);
    checkOutput({name, " setup pready"}, 32'(pready0), 32'd0);
    @(posedge pclk); #1;
    penable0 = 1'b1;
    @(negedge pclk);
    checkOutput({name, " access pready"}, 32'(pready0), 32'd1);
    checkOutput({name, " prdata"}, prdata0, expData);
    checkOutput({name, " pslverr"}, 32'(pslverr0), 32'(expErr));
    @(posedge pclk); #1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 8'd5,  32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 8'd10, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 8'd10, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 8'd50, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vecs[4]  = '{1'b0, 8'd50, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b0, 8'd70, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b1, 8'd70, 32'hCAFE_F00D, 32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b0, 8'd6,  32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b1, 8'd63, 32'h1111_1111, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b1, 8'd47, 32'h2222_2222, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b0, 8'd47, 32'h0000_0000, 32'h2222_2222, 1'b0};
    vecs[11] = '{1'b0, 8'd63, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 8'd64, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[13] = '{1'b1, 8'd0,  32'h5A5A_A5A5, 32'h0000_0000, 1'b0};
    vecs[14] = '{1'b0, 8'd0,  32'h0000_0000, 32'h5A5A_A5A5, 1'b0};

    preset = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    psel0 = 1'b0; penable0 = 1'b0; pwrite0 = 1'b0; paddr0 = '0; pwdata0 = '0;
    repeat (2) @(posedge pclk);
    #1;
    checkOutput("reset pready", 32'(pready), 32'd0);
    checkOutput("reset prdata", prdata, 32'd0);
    checkOutput("reset pslverr", 32'(pslverr), 32'd0);
    checkOutput("reset pready0", 32'(pready0), 32'd0);
    preset = 1'b0;
    @(posedge pclk); #1;

    // Table vectors run back to back with no idle cycle in between.
    for (int i = 0; i < NVEC; i++) begin
      runChecked(vecs[i].write, vecs[i].addr, vecs[i].wdata,
                 vecs[i].expData, vecs[i].expErr, $sformatf("vec%0d", i));
    end
    goIdle();

    // Abort: select drops in the first access cycle, nothing commits.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd3; pwdata = 32'hAAAA_5555;
    @(posedge pclk); #1;
    psel = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge pclk);
      checkOutput($sformatf("abort pready c%0d", c), 32'(pready), 32'd0);
      @(posedge pclk); #1;
    end
    runChecked(1'b0, 8'd3, 32'h0, 32'h0, 1'b0, "abort readback");
    goIdle();

    // Reset in the ready cycle of a read forces outputs low at once.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'd47; pwdata = '0;
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (2) begin @(posedge pclk); #1; end
    checkOutput("pre-reset pready", 32'(pready), 32'd1);
    checkOutput("pre-reset prdata", prdata, 32'h2222_2222);
    #2 preset = 1'b1;
    #1;
    checkOutput("async reset pready", 32'(pready), 32'd0);
    checkOutput("async reset prdata", prdata, 32'd0);
    checkOutput("async reset pslverr", 32'(pslverr), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    @(posedge pclk); #1;

    // Reset in the middle of a write access leaves addr 3 unwritten.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd3; pwdata = 32'h0000_0077;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    #2 preset = 1'b1;
    #1;
    checkOutput("mid-write reset pready", 32'(pready), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    @(posedge pclk); #1;
    runChecked(1'b0, 8'd3, 32'h0, 32'h0, 1'b0, "post-reset addr3");
    runChecked(1'b0, 8'd10, 32'h0, 32'h0, 1'b0, "post-reset addr10");
    goIdle();

    // Zero-wait build: an access phase with no setup gets no response.
    psel0 = 1'b1; penable0 = 1'b1; pwrite0 = 1'b0; paddr0 = 8'd1;
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      checkOutput($sformatf("no-setup pready0 c%0d", c), 32'(pready0), 32'd0);
      @(posedge pclk); #1;
    end
    psel0 = 1'b0; penable0 = 1'b0;
    @(posedge pclk); #1;
    applyStimulus0(1'b0, 8'd1, 32'h0, 32'h0, 1'b0, "z read1");
    applyStimulus0(1'b1, 8'd1, 32'h1357_9BDF, 32'h0, 1'b0, "z write1");
    applyStimulus0(1'b1, 8'd2, 32'h2468_ACE0, 32'h0, 1'b0, "z write2");
    applyStimulus0(1'b0, 8'd1, 32'h0, 32'h1357_9BDF, 1'b0, "z readback1");
    applyStimulus0(1'b0, 8'd2, 32'h0, 32'h2468_ACE0, 1'b0, "z readback2");
    applyStimulus0(1'b1, 8'd48, 32'hFFFF_0000, 32'h0, 1'b1, "z write ro");
    psel0 = 1'b0; penable0 = 1'b0;
    @(posedge pclk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
